// File: rtl/spi_sram_pkg.sv
// -----------------------------------------------------------------------------
// spi_sram_pkg
// Shared definitions for the SPI SRAM subsystem: the arbiter state encoding,
// one-hot grant encodings, SRAM command bytes and the word address width.
// pick_winner() is the 2-way arbitration decision used by spi_sram_arbiter.
// -----------------------------------------------------------------------------
package spi_sram_pkg;

   localparam int         ADR_W     = 14;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   // One-hot owner: bit0 = ibus (s0), bit1 = dbus (s1).
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_S0   = 2'b01;
   localparam logic [1:0] GNT_S1   = 2'b10;

   // On a tie, round-robin hands the bus to whoever was not granted last;
   // fixed priority always favours the dbus.
   function automatic logic [1:0] pick_winner(input logic       req0,
                                              input logic       req1,
                                              input logic       rr,
                                              input logic [1:0] last);
      logic [1:0] win;
      win = GNT_NONE;
      if (req0 && req1)
         win = (rr && (last == GNT_S1)) ? GNT_S0 : GNT_S1;
      else if (req1)
         win = GNT_S1;
      else if (req0)
         win = GNT_S0;
      return win;
   endfunction

endpackage

// File: rtl/spi_sram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_sram_arbiter
// Two-master arbiter in front of a single SPI SRAM controller. The controller
// is instantiated next to this block at the level above, sharing rst_n.
//
// Parameters
//   RR        1 = round-robin on ties, 0 = fixed priority to s1 (dbus)
// Ports
//   clk, rst_n                         clock, async active-low reset
//   s0_cyc/s0_adr                      ibus read request (held until s0_ack)
//   s0_dat_o/s0_ack                    ibus read data / acknowledge
//   s1_cyc/s1_adr/s1_we/s1_dat_i/s1_sel dbus request (held until s1_ack)
//   s1_dat_o/s1_ack                    dbus read data / acknowledge
//   m_cyc/m_adr/m_we/m_dat_i/m_sel     request to the SPI SRAM controller
//   m_dat_o/m_ack                      controller read data / 1-cycle ack
//   grant                              one-hot current owner, 0 when idle
// -----------------------------------------------------------------------------
module spi_sram_arbiter
   import spi_sram_pkg::*;
#(
   parameter int RR = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0_cyc,
   input  logic [ADR_W-1:0] s0_adr,
   output logic [31:0]      s0_dat_o,
   output logic             s0_ack,
   input  logic             s1_cyc,
   input  logic [ADR_W-1:0] s1_adr,
   input  logic             s1_we,
   input  logic [31:0]      s1_dat_i,
   input  logic [3:0]       s1_sel,
   output logic [31:0]      s1_dat_o,
   output logic             s1_ack,
   output logic             m_cyc,
   output logic [ADR_W-1:0] m_adr,
   output logic             m_we,
   output logic [31:0]      m_dat_i,
   output logic [3:0]       m_sel,
   input  logic [31:0]      m_dat_o,
   input  logic             m_ack,
   output logic [1:0]       grant
);

   arb_state_e state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] last_q,  last_d;
   logic [1:0] winner;

   assign winner = pick_winner(s0_cyc, s1_cyc, RR != 0, last_q);

   // last_q resets to s1 so the first round-robin tie goes to s0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= GNT_NONE;
         last_q  <= GNT_S1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      m_cyc    = 1'b0;
      m_adr    = '0;
      m_we     = 1'b0;
      m_dat_i  = '0;
      m_sel    = 4'h0;
      s0_ack   = 1'b0;
      s1_ack   = 1'b0;

      unique case (state_q)
         // GAP holds m_cyc low for one cycle so the controller never sees
         // a stale request straight after its own ack.
         IDLE, GAP: begin
            if (winner != GNT_NONE) begin
               state_d = BUSY;
               grant_d = winner;
               last_d  = winner;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // Non-preemptive: the owner keeps the bus until m_ack, even if
            // it drops cyc; that late ack is swallowed by the cyc gating.
            m_cyc = (grant_q != GNT_NONE);
            if (m_ack) begin
               state_d = GAP;
               grant_d = GNT_NONE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = GNT_NONE;
         end
      endcase

      // Request mux is steered by the registered grant only.
      unique case (grant_q)
         GNT_S0: begin
            m_adr = s0_adr;
            m_sel = 4'hF;
         end
         GNT_S1: begin
            m_adr   = s1_adr;
            m_we    = s1_we;
            m_dat_i = s1_dat_i;
            m_sel   = s1_sel;
         end
         default: ;
      endcase

      s0_ack = m_cyc && m_ack && grant_q[0] && s0_cyc;
      s1_ack = m_cyc && m_ack && grant_q[1] && s1_cyc;
   end

   assign s0_dat_o = m_dat_o;
   assign s1_dat_o = m_dat_o;
   assign grant    = grant_q;

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_arbiter
// Instance 0 is round-robin, instance 1 fixed priority. A small controller
// model acks each request after lat[k] cycles and returns rd_word(adr).
// Stimulus pushes expected transactions; mon() pops one per m_ack.
// -----------------------------------------------------------------------------
module tb_spi_sram_arbiter;
   import spi_sram_pkg::*;

   typedef struct {
      logic [1:0]  gnt;
      logic        we;
      logic [13:0] adr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] rdat;
      logic        ack_exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s0_cyc [2];
   logic [13:0] s0_adr [2];
   logic [31:0] s0_dat_o [2];
   logic        s0_ack [2];
   logic        s1_cyc [2];
   logic [13:0] s1_adr [2];
   logic        s1_we [2];
   logic [31:0] s1_dat_i [2];
   logic [3:0]  s1_sel [2];
   logic [31:0] s1_dat_o [2];
   logic        s1_ack [2];
   logic        m_cyc [2];
   logic [13:0] m_adr [2];
   logic        m_we [2];
   logic [31:0] m_dat_i [2];
   logic [3:0]  m_sel [2];
   logic [31:0] m_dat_o [2];
   logic        m_ack [2];
   logic [1:0]  grant [2];

   int   total = 0;
   int   bad   = 0;
   int   lat [2];
   bit   b2b [2];
   bit   had_prev [2];
   int   cnt [2];
   exp_t sb0 [$];
   exp_t sb1 [$];

   always #5 clk = ~clk;

   spi_sram_arbiter #(.RR(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .s0_cyc(s0_cyc[0]), .s0_adr(s0_adr[0]), .s0_dat_o(s0_dat_o[0]), .s0_ack(s0_ack[0]),
      .s1_cyc(s1_cyc[0]), .s1_adr(s1_adr[0]), .s1_we(s1_we[0]), .s1_dat_i(s1_dat_i[0]),
      .s1_sel(s1_sel[0]), .s1_dat_o(s1_dat_o[0]), .s1_ack(s1_ack[0]),
      .m_cyc(m_cyc[0]), .m_adr(m_adr[0]), .m_we(m_we[0]), .m_dat_i(m_dat_i[0]),
      .m_sel(m_sel[0]), .m_dat_o(m_dat_o[0]), .m_ack(m_ack[0]), .grant(grant[0])
   );

   spi_sram_arbiter #(.RR(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .s0_cyc(s0_cyc[1]), .s0_adr(s0_adr[1]), .s0_dat_o(s0_dat_o[1]), .s0_ack(s0_ack[1]),
      .s1_cyc(s1_cyc[1]), .s1_adr(s1_adr[1]), .s1_we(s1_we[1]), .s1_dat_i(s1_dat_i[1]),
      .s1_sel(s1_sel[1]), .s1_dat_o(s1_dat_o[1]), .s1_ack(s1_ack[1]),
      .m_cyc(m_cyc[1]), .m_adr(m_adr[1]), .m_we(m_we[1]), .m_dat_i(m_dat_i[1]),
      .m_sel(m_sel[1]), .m_dat_o(m_dat_o[1]), .m_ack(m_ack[1]), .grant(grant[1])
   );

   // Memory contents as seen by the controller model.
   function automatic logic [31:0] rd_word(input logic [13:0] a);
      return (a == 14'h0004) ? 32'h1234_5678 : {16'hC0DE, 2'b00, a};
   endfunction

   // Controller model: ack lat[g] cycles after m_cyc rises, one cycle wide.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < 2; g++) begin
            m_ack[g] <= 1'b0;
            cnt[g]   <= 0;
         end
      end else begin
         for (int g = 0; g < 2; g++) begin
            m_ack[g] <= 1'b0;
            if (m_cyc[g] && !m_ack[g]) begin
               if (cnt[g] >= lat[g] - 1) begin
                  m_ack[g] <= 1'b1;
                  cnt[g]   <= 0;
               end else begin
                  cnt[g] <= cnt[g] + 1;
               end
            end else begin
               cnt[g] <= 0;
            end
         end
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++)
         m_dat_o[g] = m_ack[g] ? rd_word(m_adr[g]) : 32'h0;
   end

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d: got %h want %h", name, k, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int k);
      total++;
      bad++;
      $display("FAIL %s inst%0d", name, k);
   endtask

   function automatic exp_t mk(input logic [1:0] gnt, input logic we, input logic [13:0] adr,
                               input logic [31:0] wdat, input logic [3:0] sel,
                               input logic [31:0] rdat, input logic ack_exp);
      exp_t e;
      e.gnt = gnt; e.we = we; e.adr = adr; e.wdat = wdat;
      e.sel = sel; e.rdat = rdat; e.ack_exp = ack_exp;
      return e;
   endfunction

   task automatic push(input int k, input exp_t e);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic mon(input int k);
      logic prev;
      int   low;
      exp_t e;
      bit   have;
      prev = 1'b0;
      low  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else begin
            if (!m_cyc[k]) begin
               low = prev ? 1 : low + 1;
               if (prev) had_prev[k] = 1'b1;
            end else if (!prev && b2b[k] && had_prev[k]) begin
               chk("gap_len", k, low, 1);
            end
            prev = m_cyc[k];
            if (m_ack[k]) begin
               have = 1'b0;
               if (k == 0 && sb0.size() != 0) begin e = sb0.pop_front(); have = 1'b1; end
               if (k == 1 && sb1.size() != 0) begin e = sb1.pop_front(); have = 1'b1; end
               if (!have) begin
                  fail_now("unexpected_ack", k);
               end else begin
                  chk("grant",    k, grant[k],    e.gnt);
                  chk("m_cyc",    k, m_cyc[k],    1);
                  chk("m_adr",    k, m_adr[k],    e.adr);
                  chk("m_we",     k, m_we[k],     e.we);
                  chk("m_dat_i",  k, m_dat_i[k],  e.wdat);
                  chk("m_sel",    k, m_sel[k],    e.sel);
                  chk("s0_ack",   k, s0_ack[k],   (e.gnt == GNT_S0) && e.ack_exp);
                  chk("s1_ack",   k, s1_ack[k],   (e.gnt == GNT_S1) && e.ack_exp);
                  chk("s0_dat_o", k, s0_dat_o[k], e.rdat);
                  chk("s1_dat_o", k, s1_dat_o[k], e.rdat);
               end
            end else begin
               chk("stray_ack", k, {s1_ack[k], s0_ack[k]}, 0);
            end
         end
      end
   endtask

   initial mon(0);
   initial mon(1);

   task automatic req_s0(input int k, input int n, input logic [13:0] a0);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         s0_adr[k] = a0 + 14'(i);
         s0_cyc[k] = 1'b1;
         do begin @(negedge clk); t++; end while (!s0_ack[k] && t < 500);
         if (t >= 500) fail_now("s0_ack_timeout", k);
         @(posedge clk); #1;
      end
      s0_cyc[k] = 1'b0;
   endtask

   task automatic req_s1(input int k, input int n, input logic [13:0] a0, input logic we,
                         input logic [31:0] d0, input logic [3:0] sel);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         s1_adr[k]   = a0 + 14'(i);
         s1_we[k]    = we;
         s1_dat_i[k] = d0 + i;
         s1_sel[k]   = sel;
         s1_cyc[k]   = 1'b1;
         do begin @(negedge clk); t++; end while (!s1_ack[k] && t < 500);
         if (t >= 500) fail_now("s1_ack_timeout", k);
         @(posedge clk); #1;
      end
      s1_cyc[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      int t;
      t = 0;
      while (((k == 0) ? sb0.size() : sb1.size()) != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      total++;
      if (t >= 2000) begin
         bad++;
         $display("FAIL drain inst%0d: %0d transactions never acked", k,
                  (k == 0) ? sb0.size() : sb1.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int t;
      for (int k = 0; k < 2; k++) begin
         s0_cyc[k] = 1'b0; s0_adr[k] = '0;
         s1_cyc[k] = 1'b0; s1_adr[k] = '0; s1_we[k] = 1'b0;
         s1_dat_i[k] = '0; s1_sel[k] = 4'h0;
         lat[k] = 2; b2b[k] = 1'b0; had_prev[k] = 1'b0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_m_cyc", k, m_cyc[k], 0);
         chk("rst_grant", k, grant[k], 0);
         chk("rst_acks",  k, {s1_ack[k], s0_ack[k]}, 0);
         chk("rst_m_adr", k, m_adr[k], 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Round-robin: both rise together, 4 transactions each, s0 wins first
      for (int i = 0; i < 4; i++) begin
         push(0, mk(GNT_S0, 1'b0, 14'h100 + 14'(i), 32'h0, 4'hF, 32'hC0DE_0100 + i, 1'b1));
         push(0, mk(GNT_S1, 1'b1, 14'h200 + 14'(i), 32'hA000_0000 + i, 4'hC,
                    32'hC0DE_0200 + i, 1'b1));
      end
      b2b[0] = 1'b1; had_prev[0] = 1'b0;
      fork
         req_s0(0, 4, 14'h100);
         req_s1(0, 4, 14'h200, 1'b1, 32'hA000_0000, 4'hC);
      join
      drain(0);
      b2b[0] = 1'b0;

      // dbus write from IDLE: m_cyc one cycle after the request
      push(0, mk(GNT_S1, 1'b1, 14'h0010, 32'hDEAD_BEEF, 4'hF, 32'hC0DE_0010, 1'b1));
      fork
         req_s1(0, 1, 14'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
         begin
            @(negedge clk);
            chk("lat_idle_m_cyc", 0, m_cyc[0], 0);
            @(negedge clk);
            chk("lat_busy_m_cyc", 0, m_cyc[0], 1);
            chk("lat_busy_grant", 0, grant[0], 2'b10);
            chk("lat_busy_m_adr", 0, m_adr[0], 14'h0010);
         end
      join
      drain(0);

      // dbus read with partial byte select
      push(0, mk(GNT_S1, 1'b0, 14'h0033, 32'h0000_0055, 4'h6, 32'hC0DE_0033, 1'b1));
      req_s1(0, 1, 14'h0033, 1'b0, 32'h0000_0055, 4'h6);
      drain(0);

      // ibus read: data broadcast, we forced low, write data forced to zero
      push(0, mk(GNT_S0, 1'b0, 14'h0004, 32'h0, 4'hF, 32'h1234_5678, 1'b1));
      req_s0(0, 1, 14'h0004);
      drain(0);

      // dbus drops cyc mid-transfer; late ack discarded; pending s0 follows
      lat[0] = 58;
      push(0, mk(GNT_S1, 1'b1, 14'h0040, 32'hCAFE_F00D, 4'hF, 32'hC0DE_0040, 1'b0));
      push(0, mk(GNT_S0, 1'b0, 14'h0020, 32'h0, 4'hF, 32'hC0DE_0020, 1'b1));
      b2b[0] = 1'b1; had_prev[0] = 1'b0;
      s1_adr[0] = 14'h0040; s1_we[0] = 1'b1; s1_dat_i[0] = 32'hCAFE_F00D;
      s1_sel[0] = 4'hF; s1_cyc[0] = 1'b1;
      @(posedge clk); #1;
      fork
         req_s0(0, 1, 14'h0020);
         begin
            repeat (3) @(posedge clk);
            #1 s1_cyc[0] = 1'b0;
            @(negedge clk);
            chk("hold_grant", 0, grant[0], 2'b10);
            chk("hold_m_cyc", 0, m_cyc[0], 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!m_ack[0] && t < 200);
            if (t >= 200) fail_now("late_ack_timeout", 0);
            @(posedge clk); #1;
            lat[0] = 3;
         end
      join
      drain(0);
      b2b[0] = 1'b0;

      // Reset mid-BUSY abandons the transfer; s0 is then served normally
      lat[0] = 100;
      s0_adr[0] = 14'h0007; s0_cyc[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_m_cyc", 0, m_cyc[0], 1);
      chk("pre_rst_grant", 0, grant[0], 2'b01);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_m_cyc", 0, m_cyc[0], 0);
      chk("mid_rst_grant", 0, grant[0], 0);
      chk("mid_rst_acks",  0, {s1_ack[0], s0_ack[0]}, 0);
      @(posedge clk); #1;
      lat[0] = 2;
      push(0, mk(GNT_S0, 1'b0, 14'h0007, 32'h0, 4'hF, 32'hC0DE_0007, 1'b1));
      rst_n = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s0_ack[0] && t < 200);
      if (t >= 200) fail_now("post_rst_timeout", 0);
      @(posedge clk); #1;
      s0_cyc[0] = 1'b0;
      drain(0);

      // Fixed priority: s1 wins while it requests, s0 only afterwards
      for (int i = 0; i < 3; i++)
         push(1, mk(GNT_S1, 1'b1, 14'h300 + 14'(i), 32'hB000_0000 + i, 4'h3,
                    32'hC0DE_0300 + i, 1'b1));
      for (int i = 0; i < 2; i++)
         push(1, mk(GNT_S0, 1'b0, 14'h050 + 14'(i), 32'h0, 4'hF, 32'hC0DE_0050 + i, 1'b1));
      b2b[1] = 1'b1; had_prev[1] = 1'b0;
      fork
         req_s1(1, 3, 14'h300, 1'b1, 32'hB000_0000, 4'h3);
         req_s0(1, 2, 14'h050);
      join
      drain(1);
      b2b[1] = 1'b0;

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_sram_arbiter.md
SPI_SRAM_ARBITER -- requirements
Module: spi_sram_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1, meaning 1 = round-robin and 0 = fixed priority to requester 1 (dbus).
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s0_cyc  in  1  ibus request, read-only, held until s0_ack.
REQ-005 SHALL have port s0_adr  in  14  ibus word address.
REQ-006 SHALL have port s0_dat_o  out  32  ibus read data.
REQ-007 SHALL have port s0_ack  out  1  ibus acknowledge.
REQ-008 SHALL have port s1_cyc  in  1  dbus request, held until s1_ack.
REQ-009 SHALL have ports s1_adr, s1_we, s1_dat_i, s1_sel  in  14/1/32/4  dbus address, write enable, write data, byte select.
REQ-010 SHALL have ports s1_dat_o and s1_ack  out  32/1  dbus read data and acknowledge.
REQ-011 SHALL have ports m_cyc, m_adr, m_we, m_dat_i, m_sel  out  1/14/1/32/4  request to the SPI SRAM controller.
REQ-012 SHALL have ports m_dat_o and m_ack  in  32/1  controller read data and single-cycle acknowledge.
REQ-013 SHALL have port grant  out  2  one-hot current owner (bit0 = s0, bit1 = s1); 2'b00 when no owner.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and GAP.
REQ-015 IDLE or GAP with any sX_cyc high: SHALL register the winner into grant and go to BUSY. GAP with no request: SHALL go to IDLE.
REQ-016 BUSY: m_cyc SHALL be 1 and m_adr/m_we/m_dat_i/m_sel SHALL be driven from the owner. The mux SHALL select from the grant register only, never combinationally from requests.
REQ-017 Owner s0: m_we SHALL be 0, m_dat_i 0, m_sel 4'hF.
REQ-018 BUSY with m_ack=1: ack SHALL pass combinationally to the owner's sX_ack in the same cycle; the FSM SHALL go to GAP and clear grant.
REQ-019 In IDLE and GAP, m_cyc SHALL be 0. This guarantees at least 1 low cycle between transactions, matching the controller's post-ack idle cycle so it never re-launches on a stale request.
REQ-020 m_dat_o SHALL be broadcast to s0_dat_o and s1_dat_o. Only the owner's ack SHALL assert; the non-owner's ack SHALL stay 0 at all times.
REQ-021 RR=1 tie (both requesting): the requester not granted last SHALL win. last_grant SHALL update on every grant.
REQ-022 RR=0 tie: s1 SHALL win.
REQ-023 Owner drops cyc mid-transaction (protocol violation): the FSM SHALL remain BUSY until m_ack; the ack SHALL be discarded (sX_ack gated by the owner's current cyc).
REQ-024 Latency: request in IDLE gives m_cyc high the next cycle. Back-to-back requests give exactly 1 cycle of m_cyc low.
REQ-025 Arbitration SHALL be non-preemptive: grant SHALL be constant from grant cycle until m_ack.

Reset
REQ-026 On rst_n low, asynchronously: state = IDLE, grant = 0, last_grant = s1 (so s0 wins the first RR tie), m_cyc = 0, s0_ack = s1_ack = 0.
REQ-027 Reset mid-transaction SHALL abandon the transfer with no ack issued. The controller is reset by the same rst_n.
REQ-028 Outputs driven from grant SHALL read as 0 while grant is 0.

Structure
REQ-029 A shared package spi_sram_pkg SHALL hold:
- the arbiter state enum;
- grant encodings GNT_NONE/GNT_S0/GNT_S1;
- SRAM command constants CMD_READ = 8'h03 and CMD_WRITE = 8'h02 (for reuse by controller and benches);
- ADR_W = 14.
REQ-030 No sub-module SHALL be used. The 2-way winner pick SHALL be a function in spi_sram_pkg. The SPI SRAM controller SHALL be instantiated beside the arbiter, not inside it.

Verification
REQ-031 s1 write adr 0x0010, dat 0xDEADBEEF, sel 4'hF from IDLE -> m_cyc=1 next cycle, m_we=1, m_adr=0x0010, m_dat_i=0xDEADBEEF; s1_ack coincident with m_ack; s0_ack never 1.
REQ-032 s0 read adr 0x0004, bench m_dat_o = 0x12345678 with m_ack -> s0_dat_o = 0x12345678 and s0_ack=1 in the same cycle; m_we=0.
REQ-033 RR=1, both cyc rise together after reset, held for 4 transactions each -> grant sequence s0, s1, s0, s1; exactly 1 cycle m_cyc=0 between each.
REQ-034 RR=0, both held continuously -> s1 granted every time; s0 granted only after s1_cyc drops.
REQ-035 s1 drops cyc 3 cycles into BUSY; m_ack arrives 55 cycles later -> s1_ack stays 0; FSM enters GAP; a pending s0 is granted the following cycle.
REQ-036 rst_n asserted mid-BUSY -> m_cyc=0 and grant=0 immediately; no ack is seen; after release, an s0 request is served normally.
